// File: rtl/y_sig_pkg.sv
// rtl/y_sig_pkg.sv - shared CRC constants and FSM state encoding for the y signature compactor
package y_sig_pkg;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/y_sig_crc_step.sv
// rtl/y_sig_crc_step.sv - combinational CRC-32/MPEG-2 update over one chunk, chunk bits fed MSB-first
module y_sig_crc_step
    import y_sig_pkg::*;
#(
    parameter int CHUNK_W = 32
) (
    input  logic [31:0]        sig,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [31:0]        next_sig
);

    always_comb begin
        next_sig = sig;
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            if (next_sig[31] ^ chunk[i]) begin
                next_sig = {next_sig[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                next_sig = {next_sig[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/y_sig_compactor.sv
// rtl/y_sig_compactor.sv - folds DUT output samples into a CRC-32 frame signature, one chunk per cycle
// Optional signature compare against expected_sig is enabled by macro Y_SIG_COMPARE_EN.
module y_sig_compactor
    import y_sig_pkg::*;
#(
    parameter int Y_W     = 1490,
    parameter int CHUNK_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [Y_W-1:0] y,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic           sig_valid,
    output logic [31:0]    signature,
    output logic [15:0]    sample_count
`ifdef Y_SIG_COMPARE_EN
    ,
    input  logic [31:0]    expected_sig,
    output logic           mismatch
`endif
);

    localparam int NCHUNK = (Y_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W  = NCHUNK * CHUNK_W;
    localparam int IDX_W  = $clog2(NCHUNK + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_e             state_q, state_d;
    logic [PAD_W-1:0]   y_q, y_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        sig_q, sig_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               accept;
    logic [CHUNK_W-1:0] chunk;
    logic [31:0]        crc_next;

    // Outputs are gated by rst so nothing is offered or flagged during reset cycles.
    assign in_ready     = (state_q == IDLE) && !rst;
    assign sig_valid    = (state_q == DONE) && !rst;
    assign signature    = sig_q;
    assign sample_count = cnt_q;
    assign accept       = in_valid && in_ready;
    assign chunk        = y_q[int'(idx_q) * CHUNK_W +: CHUNK_W];

    y_sig_crc_step #(
        .CHUNK_W (CHUNK_W)
    ) u_crc_step (
        .sig      (sig_q),
        .chunk    (chunk),
        .next_sig (crc_next)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        last_d  = last_q;
        idx_d   = idx_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Zero-extension supplies the padding of the top chunk.
                    y_d     = PAD_W'(y);
                    last_d  = in_last;
                    idx_d   = '0;
                    state_d = FOLD;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            FOLD: begin
                sig_d = crc_next;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = last_q ? DONE : IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                sig_d   = CRC_SEED;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            sig_q   <= CRC_SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef Y_SIG_COMPARE_EN
    logic mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == DONE) begin
            mismatch_d = (sig_q != expected_sig);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_y_sig_compactor.sv
// tb/tb_y_sig_compactor.sv - directed self-checking bench for y_sig_compactor (default and 72/8 builds)
module tb_y_sig_compactor;

    localparam logic [31:0] SEED = 32'hFFFF_FFFF;

    logic          clk;
    logic          rst;
    logic [1489:0] ya;
    logic          va, la;
    logic          in_ready_a, sig_valid_a;
    logic [31:0]   signature_a;
    logic [15:0]   sample_count_a;
    logic [71:0]   yb;
    logic          vb, lb;
    logic          in_ready_b, sig_valid_b;
    logic [31:0]   signature_b;
    logic [15:0]   sample_count_b;
`ifdef Y_SIG_COMPARE_EN
    logic [31:0]   exp_a, exp_b;
    logic          mismatch_a, mismatch_b;
`endif

    int            checks = 0;
    int            errors = 0;
    int            low, first, pulses, k;
    int            acc_t[4];
    logic          accepting;
    logic [31:0]   sig, exp_sig;
    logic [15:0]   cnt;
    logic [1489:0] y1, y2, y3, y4;

    y_sig_compactor dut_a (
        .clk          (clk),
        .rst          (rst),
        .y            (ya),
        .in_valid     (va),
        .in_last      (la),
        .in_ready     (in_ready_a),
        .sig_valid    (sig_valid_a),
        .signature    (signature_a),
        .sample_count (sample_count_a)
`ifdef Y_SIG_COMPARE_EN
        ,
        .expected_sig (exp_a),
        .mismatch     (mismatch_a)
`endif
    );

    y_sig_compactor #(
        .Y_W     (72),
        .CHUNK_W (8)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .y            (yb),
        .in_valid     (vb),
        .in_last      (lb),
        .in_ready     (in_ready_b),
        .sig_valid    (sig_valid_b),
        .signature    (signature_b),
        .sample_count (sample_count_b)
`ifdef Y_SIG_COMPARE_EN
        ,
        .expected_sig (exp_b),
        .mismatch     (mismatch_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_fold(input logic [31:0] seed, input logic [1489:0] v,
                                             input int yw, input int cw);
        logic [31:0] s;
        logic        b;
        int          nch;
        s   = seed;
        nch = (yw + cw - 1) / cw;
        for (int c = 0; c < nch; c++) begin
            for (int j = cw - 1; j >= 0; j--) begin
                b = (c * cw + j < yw) ? v[c * cw + j] : 1'b0;
                s = (s[31] ^ b) ? ({s[30:0], 1'b0} ^ 32'h04C1_1DB7) : {s[30:0], 1'b0};
            end
        end
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [1489:0] v, input logic last);
        ya = v;
        la = last;
        va = 1'b1;
        tick;
        va = 1'b0;
    endtask

    task automatic send_b(input logic [71:0] v, input logic last);
        yb = v;
        lb = last;
        vb = 1'b1;
        tick;
        vb = 1'b0;
    endtask

    // Watches one DUT for max_n cycles starting at cycle 1 after the accepting edge.
    task automatic watch(input bit sel_b, input int max_n, output int o_low, output int o_first,
                         output int o_pulses, output logic [31:0] o_sig, output logic [15:0] o_cnt);
        bit   seen_rdy;
        logic rdy, sv;
        o_low = 0; o_first = 0; o_pulses = 0; o_sig = '0; o_cnt = '0; seen_rdy = 1'b0;
        for (int n = 1; n <= max_n; n++) begin
            rdy = sel_b ? in_ready_b : in_ready_a;
            sv  = sel_b ? sig_valid_b : sig_valid_a;
            if (!rdy && !seen_rdy) o_low++;
            else seen_rdy = 1'b1;
            if (sv === 1'b1) begin
                o_pulses++;
                if (o_first == 0) o_first = n;
                o_sig = sel_b ? signature_b : signature_a;
                o_cnt = sel_b ? sample_count_b : sample_count_a;
            end
            tick;
        end
    endtask

    initial begin
        rst = 1'b1; va = 1'b0; la = 1'b0; ya = '0; vb = 1'b0; lb = 1'b0; yb = '0;
`ifdef Y_SIG_COMPARE_EN
        exp_a = '0;
        exp_b = 32'h0376_E6E7;
`endif
        for (int i = 0; i < 1490; i++) begin
            y1[i] = 1'b1;
            y2[i] = (i % 2 == 0);
            y3[i] = (i % 7 == 3);
            y4[i] = (i % 5 == 1);
        end

        tick; tick; tick;
        check("rst_ready_a", in_ready_a, 0);
        check("rst_valid_a", sig_valid_a, 0);
        check("rst_sig_a", signature_a, SEED);
        check("rst_cnt_a", sample_count_a, 0);
        check("rst_ready_b", in_ready_b, 0);
        check("rst_sig_b", signature_b, SEED);
`ifdef Y_SIG_COMPARE_EN
        check("rst_mismatch_b", mismatch_b, 0);
`endif
        rst = 1'b0;
        #1;
        check("ready_after_rst_a", in_ready_a, 1);
        check("ready_after_rst_b", in_ready_b, 1);

        // "123456789" check vector on the 72/8 build
        send_b(72'h39_3837_3635_3433_3231, 1'b1);
        watch(1'b1, 14, low, first, pulses, sig, cnt);
        check("b_ready_low", low, 10);
        check("b_valid_cycle", first, 10);
        check("b_pulses", pulses, 1);
        check("b_sig", sig, 32'h0376_E6E7);
        check("b_cnt", cnt, 1);
        check("b_ready_after", in_ready_b, 1);
        check("b_sig_reload", signature_b, SEED);
        check("b_cnt_clear", sample_count_b, 0);
`ifdef Y_SIG_COMPARE_EN
        check("b_mismatch_match", mismatch_b, 0);
        exp_b = '0;
        send_b(72'h39_3837_3635_3433_3231, 1'b1);
        watch(1'b1, 14, low, first, pulses, sig, cnt);
        check("b_mismatch_diff", mismatch_b, 1);
`endif

        // all-zero sample, default build
        send_a('0, 1'b1);
        watch(1'b0, 60, low, first, pulses, sig, cnt);
        check("a0_ready_low", low, 48);
        check("a0_valid_cycle", first, 48);
        check("a0_pulses", pulses, 1);
        check("a0_sig", sig, ref_fold(SEED, '0, 1490, 32));
        check("a0_cnt", cnt, 1);
        check("a0_ready_after", in_ready_a, 1);

        // three samples with in_valid held high throughout
        exp_sig = ref_fold(ref_fold(ref_fold(SEED, y1, 1490, 32), y2, 1490, 32), y3, 1490, 32);
        ya = y1; la = 1'b0; va = 1'b1; k = 0; pulses = 0;
        for (int n = 0; n < 200; n++) begin
            accepting = in_ready_a && va;
            if (sig_valid_a === 1'b1) begin
                pulses++;
                sig = signature_a;
                cnt = sample_count_a;
            end
            tick;
            if (accepting) begin
                if (k < 4) acc_t[k] = n;
                k++;
                case (k)
                    1:       ya = y2;
                    2:       begin ya = y3; la = 1'b1; end
                    default: va = 1'b0;
                endcase
            end
        end
        va = 1'b0;
        check("multi_accepts", k, 3);
        check("multi_gap1", acc_t[1] - acc_t[0], 48);
        check("multi_gap2", acc_t[2] - acc_t[1], 48);
        check("multi_pulses", pulses, 1);
        check("multi_cnt", cnt, 3);
        check("multi_sig", sig, exp_sig);

        // reset while folding chunk 20
        send_a(y1, 1'b1);
        repeat (20) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("abort_sig", signature_a, SEED);
        check("abort_cnt", sample_count_a, 0);
        watch(1'b0, 60, low, first, pulses, sig, cnt);
        check("abort_no_pulse", pulses, 0);
        check("abort_ready", low, 0);
        send_a(y4, 1'b1);
        watch(1'b0, 60, low, first, pulses, sig, cnt);
        check("fresh_pulses", pulses, 1);
        check("fresh_sig", sig, ref_fold(SEED, y4, 1490, 32));
        check("fresh_cnt", cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/y_sig_compactor.md
Y_SIG_COMPACTOR -- requirements
Module: y_sig_compactor

Interface
REQ-001 SHALL have parameter Y_W, default 1490, giving the width of the design-under-test output vector y.
REQ-002 SHALL have parameter CHUNK_W, default 32, legal range 1..32, giving the bits folded into the signature per cycle.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port y, input, Y_W bits: the sample vector from the DUT output.
REQ-006 SHALL have port in_valid, input, 1 bit: y holds a sample.
REQ-007 SHALL have port in_last, input, 1 bit: the current sample closes the frame; qualified by in_valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 SHALL have port sig_valid, output, 1 bit: a one-cycle pulse marking the signature as final.
REQ-010 SHALL have port signature, output, 32 bits: the running or final CRC signature.
REQ-011 SHALL have port sample_count, output, 16 bits: the number of samples accepted in the current frame.

Function
REQ-012 SHALL have states IDLE, FOLD and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; a sample is accepted when in_valid&in_ready at a rising edge.
REQ-014 SHALL, on accept, capture y and in_last, increment sample_count saturating at 16'hFFFF, and move IDLE->FOLD with chunk index 0.
REQ-015 SHALL number chunks NCHUNK=ceil(Y_W/CHUNK_W); chunk k = y[k*CHUNK_W +: CHUNK_W], LSB chunk first, with the last chunk zero-padded above bit Y_W-1.
REQ-016 SHALL fold one chunk per cycle in FOLD using CRC-32/MPEG-2: poly 0x04C11DB7, chunk bits fed MSB-first, no reflection, seed 0xFFFFFFFF, no final XOR.
REQ-017 SHALL, after folding chunk NCHUNK-1, go to DONE if the captured in_last=1, otherwise to IDLE.
REQ-018 SHALL hold DONE for exactly one cycle with sig_valid=1, signature final and sample_count final, then go to IDLE.
REQ-019 SHALL reload the signature with the seed and clear sample_count on the DONE->IDLE transition.
REQ-020 SHALL place the sig_valid pulse exactly NCHUNK+1 cycles after the accepting edge, i.e. 48 cycles with default parameters.
REQ-021 SHALL ignore in_valid while in FOLD or DONE; the source must hold y and in_last stable until it is accepted.
REQ-022 SHALL update signature only in FOLD and hold it in all other states.

Reset
REQ-023 SHALL, while rst=1, set the state to IDLE, signature to 0xFFFFFFFF, sample_count to 0, sig_valid to 0, in_ready to 0, and the chunk index to 0.
REQ-024 SHALL, on reset mid-FOLD or mid-DONE, discard the partial frame; no sig_valid pulse may follow.
REQ-025 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with macro Y_SIG_COMPARE_EN defined, add input expected_sig (32 bits) and output mismatch (1 bit).
REQ-027 SHALL, when Y_SIG_COMPARE_EN is defined, register mismatch = (signature != expected_sig) at the DONE cycle and hold it until reset or the next DONE.
REQ-028 SHALL clear mismatch to 0 on reset when Y_SIG_COMPARE_EN is defined.
REQ-029 SHALL, with Y_SIG_COMPARE_EN undefined, omit both ports and all compare logic.

Structure
REQ-030 SHALL place CRC_POLY, CRC_SEED and the state enumeration in shared package y_sig_pkg.
REQ-031 SHALL implement the combinational single-chunk CRC update as sub-module y_sig_crc_step (inputs sig and chunk, output next sig).

Verification
REQ-032 SHALL cover: Y_W=72, CHUNK_W=8, y=72'h393837363534333231, in_last=1 -> sig_valid after 10 cycles, signature 0x0376E6E7, sample_count 1.
REQ-033 SHALL cover: defaults, y=0, in_last=1 -> in_ready low for 48 cycles, one sig_valid pulse at cycle 48, signature equal to the reference model, then in_ready=1.
REQ-034 SHALL cover: three samples with in_last only on the third -> exactly one sig_valid, sample_count 3, signature equal to the reference-model fold of all three samples.
REQ-035 SHALL cover: in_valid held high continuously -> samples accepted every 48 cycles, none lost or duplicated.
REQ-036 SHALL cover: rst pulsed at FOLD chunk 20 -> no sig_valid, signature 0xFFFFFFFF, next frame matches a fresh reference.
REQ-037 SHALL cover, with Y_SIG_COMPARE_EN: expected_sig=0x0376E6E7 on the REQ-032 stimulus -> mismatch=0; expected_sig=0 -> mismatch=1.
